// File: rtl/pattern_detector.sv
// Serial bit-pattern detector: matches the last LEN accepted bits against a
// loadable pattern and counts detections with a saturating counter.
module pattern_detector #(
   parameter int LEN = 4,
   parameter int CNT_W = 8,
   parameter logic [LEN-1:0] DEF_PAT = LEN'(4'b0101)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic                       din,
   input  logic                       overlap,
   input  logic                       load,
   input  logic [LEN-1:0]             pat_in,
   input  logic                       clr,
   output logic                       match,
   output logic [CNT_W-1:0]           match_cnt,
   output logic                       cnt_sat,
   output logic [$clog2(LEN+1)-1:0]   fill
);

   localparam int FW = $clog2(LEN+1);
   localparam logic [FW-1:0] FULL = FW'(LEN);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [LEN-1:0] pattern;
   logic [LEN-1:0] hist;
   logic [LEN-1:0] histNext;
   logic [FW-1:0]  fillNext;
   logic           hit;

   // A hit needs a full window, so stale history bits beyond fill never count.
   always_comb begin
      histNext = {hist[LEN-2:0], din};
      fillNext = (fill == FULL) ? FULL : fill + FW'(1);
      hit      = (fillNext == FULL) && (histNext == pattern);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pattern   <= DEF_PAT;
         hist      <= '0;
         fill      <= '0;
         match     <= 1'b0;
         match_cnt <= '0;
         cnt_sat   <= 1'b0;
      end else if (clr) begin
         hist      <= '0;
         fill      <= '0;
         match     <= 1'b0;
         match_cnt <= '0;
         cnt_sat   <= 1'b0;
      end else if (load) begin
         pattern <= pat_in;
         fill    <= '0;
         match   <= 1'b0;
      end else if (en) begin
         hist  <= histNext;
         match <= hit;
         // Non-overlapping mode restarts the window so the next match needs LEN fresh bits.
         if (hit && !overlap) begin
            fill <= '0;
         end else begin
            fill <= fillNext;
         end
         if (hit) begin
            if (match_cnt == CNT_MAX) begin
               cnt_sat <= 1'b1;
            end else begin
               match_cnt <= match_cnt + CNT_W'(1);
            end
         end
      end else begin
         match <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pattern_detector.sv
// Self-checking bench for pattern_detector (LEN=4, CNT_W=2): directed scenarios
// plus randomized traffic compared against a queue-based reference model.
module tb_pattern_detector;

   localparam int LEN = 4;
   localparam int CNT_W = 2;
   localparam int CMAX = (1 << CNT_W) - 1;

   logic           clk;
   logic           rst;
   logic           en;
   logic           din;
   logic           overlap;
   logic           load;
   logic [LEN-1:0] pat_in;
   logic           clr;
   logic           match;
   logic [CNT_W-1:0] match_cnt;
   logic           cnt_sat;
   logic [2:0]     fill;

   int total;
   int bad;

   bit             mq[$];
   logic [LEN-1:0] mPat;
   int             mCnt;
   bit             mSat;
   bit             mMatch;

   pattern_detector #(.LEN(LEN), .CNT_W(CNT_W), .DEF_PAT(4'b0101)) dut (
      .clk(clk), .rst(rst), .en(en), .din(din), .overlap(overlap),
      .load(load), .pat_in(pat_in), .clr(clr), .match(match),
      .match_cnt(match_cnt), .cnt_sat(cnt_sat), .fill(fill)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic checkModel(input string tag);
      checkOutput({tag, "_match"}, 32'(match), 32'(mMatch));
      checkOutput({tag, "_cnt"}, 32'(match_cnt), 32'(mCnt));
      checkOutput({tag, "_sat"}, 32'(cnt_sat), 32'(mSat));
      checkOutput({tag, "_fill"}, 32'(fill), 32'(mq.size()));
   endtask

   function automatic void modelReset();
      mq.delete();
      mPat = 4'b0101;
      mCnt = 0;
      mSat = 1'b0;
      mMatch = 1'b0;
   endfunction

   // Reference: the window is the list of bits accepted since the last restart.
   function automatic void modelStep(input bit e, input bit d, input bit ov,
                                     input bit ld, input logic [LEN-1:0] p, input bit c);
      bit hitNow;
      if (c) begin
         mq.delete();
         mMatch = 1'b0;
         mCnt = 0;
         mSat = 1'b0;
      end else if (ld) begin
         mPat = p;
         mq.delete();
         mMatch = 1'b0;
      end else if (e) begin
         mq.push_back(d);
         if (mq.size() > LEN) void'(mq.pop_front());
         hitNow = (mq.size() == LEN);
         for (int i = 0; i < LEN; i++) begin
            if (hitNow && mq[i] != mPat[LEN-1-i]) hitNow = 1'b0;
         end
         mMatch = hitNow;
         if (hitNow) begin
            if (!ov) mq.delete();
            if (mCnt < CMAX) mCnt++;
            else mSat = 1'b1;
         end
      end else begin
         mMatch = 1'b0;
      end
   endfunction

   task automatic applyStimulus(input bit e, input bit d, input bit ov,
                                input bit ld, input logic [LEN-1:0] p, input bit c);
      en = e; din = d; overlap = ov; load = ld; pat_in = p; clr = c;
      @(posedge clk);
      #1;
      modelStep(e, d, ov, ld, p, c);
      checkModel("step");
   endtask

   task automatic feedBits(input logic [15:0] bits, input int n, input bit ov);
      for (int i = n - 1; i >= 0; i--) applyStimulus(1'b1, bits[i], ov, 1'b0, '0, 1'b0);
   endtask

   task automatic applyReset();
      #2 rst = 1'b0;
      #1;
      modelReset();
      checkModel("reset");
      #1 rst = 1'b1;
   endtask

   initial begin
      total = 0;
      bad = 0;
      rst = 1'b0;
      en = 1'b0; din = 1'b0; overlap = 1'b1; load = 1'b0; pat_in = '0; clr = 1'b0;
      modelReset();
      #3;
      checkModel("por");
      #4 rst = 1'b1;

      // Overlapping detection of 1011 in 1011011.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'b1011, 1'b0);
      feedBits(16'b1011011, 7, 1'b1);
      checkOutput("ovl_cnt", 32'(match_cnt), 2);

      // Non-overlapping: one hit, three leftover bits.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
      feedBits(16'b1011011, 7, 1'b0);
      checkOutput("novl_cnt", 32'(match_cnt), 1);
      checkOutput("novl_fill", 32'(fill), 3);

      // Enable gap in the middle of a partial match.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1);
      feedBits(16'b10, 2, 1'b1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'($urandom), 1'b1, 1'b0, '0, 1'b0);
      feedBits(16'b11, 2, 1'b1);
      checkOutput("gap_match", 32'(match), 1);

      // Counter saturation with back-to-back patterns.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
      for (int k = 0; k < 6; k++) begin
         feedBits(16'b1011, 4, 1'b0);
         if (k == 3) checkOutput("sat_after4", 32'(cnt_sat), 1);
      end
      checkOutput("sat_cnt", 32'(match_cnt), 3);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
      checkOutput("clr_cnt", 32'(match_cnt), 0);
      checkOutput("clr_sat", 32'(cnt_sat), 0);

      // Load wins over en; its din is dropped.
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0);
         checkOutput("zeros_match", 32'(match), (i == 3) ? 1 : 0);
      end

      // Async reset mid-pattern restores DEF_PAT and empties history.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'b1011, 1'b0);
      feedBits(16'b101, 3, 1'b1);
      applyReset();
      feedBits(16'b1, 1, 1'b1);
      checkOutput("rst_fill", 32'(fill), 1);
      checkOutput("rst_nomatch", 32'(match), 0);
      feedBits(16'b0101, 4, 1'b1);
      checkOutput("defpat_match", 32'(match), 1);

      // Randomized traffic with occasional clr, load and reset.
      begin
         bit ov;
         ov = 1'b1;
         for (int n = 0; n < 800; n++) begin
            int r;
            r = int'($urandom_range(0, 199));
            if (r == 0) begin
               applyReset();
            end else begin
               if (r < 10) ov = ~ov;
               applyStimulus(($urandom_range(0, 3) != 0), 1'($urandom), ov,
                             (r >= 10 && r < 14), 4'($urandom), (r >= 14 && r < 17));
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pattern_detector.md
PATTERN_DETECTOR -- requirements
Module: pattern_detector

Interface
REQ-001 The block SHALL have parameter LEN, default 4, giving the pattern length in bits (legal 2..16).
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the match counter width in bits (legal 1..16).
REQ-003 The block SHALL have parameter DEF_PAT, default 4'b0101 (LEN bits), giving the pattern register value after reset.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  din is valid and accepted this cycle.
REQ-007 din  input  1  serial data bit.
REQ-008 overlap  input  1  1 = overlapping detection; 0 = history restarts after each match.
REQ-009 load  input  1  one-cycle strobe; pattern register <= pat_in.
REQ-010 pat_in  input  LEN  new pattern; bit LEN-1 is the first bit in time.
REQ-011 clr  input  1  synchronous clear of history, match, counter and saturation flag.
REQ-012 match  output  1  registered Moore detection flag.
REQ-013 match_cnt  output  CNT_W  number of detections since reset/clr.
REQ-014 cnt_sat  output  1  sticky flag; match_cnt has saturated.
REQ-015 fill  output  clog2(LEN+1)  number of valid history bits, 0..LEN.

Function
REQ-016 Internal state SHALL be: a pattern register; a LEN-bit history shift register, newest bit in bit 0; the fill count.
REQ-017 On an edge with en=1, din SHALL shift into history bit 0, and fill SHALL increment, saturating at LEN.
REQ-018 A hit SHALL occur on an accepted bit when the post-shift fill equals LEN and the post-shift history equals the pattern register.
REQ-019 match SHALL be 1 for exactly the one cycle following the edge at which a hit occurs, and 0 in every other cycle.
REQ-020 Detection latency SHALL be one cycle: match rises at the same edge that accepts the final pattern bit.
REQ-021 With overlap=1, a hit SHALL leave history and fill unchanged, so the suffix bits of a match can start the next match.
REQ-022 With overlap=0, a hit SHALL set fill to 0, so the next match needs LEN fresh bits.
REQ-023 On an edge with en=0, history and fill SHALL hold, match SHALL go to 0, and en gaps SHALL NOT break a partial match.
REQ-024 On a hit, match_cnt SHALL increment by 1 if it is below 2^CNT_W-1.
REQ-025 If match_cnt is already at 2^CNT_W-1 on a hit, it SHALL hold its value and cnt_sat SHALL set to 1; cnt_sat stays 1 until clr or reset.
REQ-026 load=1 SHALL copy pat_in into the pattern register and clear fill and match; the din in that cycle SHALL be discarded.
REQ-027 clr=1 SHALL zero fill, match, match_cnt and cnt_sat; the din in that cycle SHALL be discarded; the pattern register is unchanged.
REQ-028 Priority SHALL be clr > load > en when these inputs are asserted in the same cycle.
REQ-029 overlap SHALL be sampled at the edge where a hit occurs, and changing it mid-stream SHALL NOT disturb history.
REQ-030 Unused history bits beyond fill SHALL NOT be able to cause a hit.

Reset
REQ-031 While rst=0, outputs SHALL be: match=0, match_cnt=0, cnt_sat=0, fill=0; the pattern register SHALL equal DEF_PAT.
REQ-032 Reset asserted mid-pattern SHALL discard all partial history immediately, without waiting for a clock edge.
REQ-033 The first bit accepted after rst releases SHALL be treated as the first bit of a new history.

Verification (LEN=4, pattern 1011 loaded unless stated)
REQ-034 overlap=1, din 1,0,1,1,0,1,1 with en=1 -> match pulses after bits 4 and 7; match_cnt=2.
REQ-035 overlap=0, same stream -> match pulses after bit 4 only; match_cnt=1, fill=3 at end.
REQ-036 din 1,0, then en=0 for 3 cycles, then 1,1 -> single match pulse after the last bit; match=0 during the gap.
REQ-037 CNT_W=2, overlap=0, six back-to-back 1011 patterns -> match_cnt stops at 3, cnt_sat=1 after the 4th match; clr then gives 0/0.
REQ-038 din 1,0,1, then rst pulse low, then 1 -> no match; fill=1; pattern reads back DEF_PAT (0101).
REQ-039 load with pat_in=0000 in the same cycle as en=1 and din=0, then four 0s -> match only after the 4th following 0.
